// File: rtl/trng_pkg.sv
// Shared types and defaults for the ring-oscillator TRNG blocks.
// Holds the controller state encoding, the default parameter values and
// a helper that sizes counters from their terminal count.
package trng_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WARMUP = 3'd1,
    SAMPLE = 3'd2,
    HOLD   = 3'd3,
    FAULT  = 3'd4
  } trng_ctrl_state_e;

  localparam int DEF_NUM_RO        = 4;
  localparam int DEF_WORD_WIDTH    = 32;
  localparam int DEF_WARMUP_CYCLES = 64;
  localparam int DEF_SAMPLE_DIV    = 8;
  localparam int DEF_REP_LIMIT     = 32;

  // Width of a counter that runs 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/trng_sync.sv
// N-bit two-flop synchronizer for signals asynchronous to i_clk.
// Ports: i_clk, i_rst (async, active-high), i_d (async input vector),
//        o_q (synchronized vector, two i_clk cycles behind i_d).
module trng_sync #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/trng_ro_ctrl.sv
// Ring-oscillator TRNG controller: releases the rings, waits out a warm-up,
// samples the XOR-folded ring bank at a divided rate, packs bits MSB-first
// into words and offers them over valid/ready with a one-word buffer.
// A repetition-count health test halts the rings and latches fault_o.
// Ports: clk_i/rst_i (async active-high), en_i, ro_bits_i (async rings),
//        ro_halt_o, data_o/valid_o/ready_i, busy_o, fault_o, clear_fault_i.
module trng_ro_ctrl
  import trng_pkg::*;
#(
  parameter int NUM_RO        = DEF_NUM_RO,
  parameter int WORD_WIDTH    = DEF_WORD_WIDTH,
  parameter int WARMUP_CYCLES = DEF_WARMUP_CYCLES,
  parameter int SAMPLE_DIV    = DEF_SAMPLE_DIV,
  parameter int REP_LIMIT     = DEF_REP_LIMIT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [NUM_RO-1:0]     ro_bits_i,
  output logic                  ro_halt_o,
  output logic [WORD_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  busy_o,
  output logic                  fault_o,
  input  logic                  clear_fault_i
);

  localparam int WARM_W = cnt_w(WARMUP_CYCLES);
  localparam int DIV_W  = cnt_w(SAMPLE_DIV);
  localparam int BIT_W  = cnt_w(WORD_WIDTH);
  localparam int REP_W  = cnt_w(REP_LIMIT);

  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_CYCLES - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_WIDTH - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REP_LIMIT - 1);

  trng_ctrl_state_e r_state;
  trng_ctrl_state_e w_state_nxt;

  logic [WARM_W-1:0]     r_warm_cnt;
  logic [DIV_W-1:0]      r_div_cnt;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic [REP_W-1:0]      r_rep_cnt;
  logic                  r_prev_bit;
  logic [WORD_WIDTH-1:0] r_shift;
  logic [WORD_WIDTH-1:0] r_data;
  logic                  r_valid;

  logic [NUM_RO-1:0]     w_sync;
  logic                  w_raw_bit;
  logic                  w_tick;
  logic                  w_word_done;
  logic                  w_rep_hit;
  logic                  w_buf_free;
  logic                  w_xfer;
  logic [WORD_WIDTH-1:0] w_word;

  // FSM strobes towards the datapath
  logic w_enter_warm;
  logic w_enter_sample;
  logic w_enter_fault;
  logic w_load_word;   // load the word completing on this tick
  logic w_load_shift;  // load the word parked in r_shift during HOLD

  trng_sync #(
    .WIDTH (NUM_RO)
  ) u_sync (
    .i_clk (clk_i),
    .i_rst (rst_i),
    .i_d   (ro_bits_i),
    .o_q   (w_sync)
  );

  assign w_raw_bit   = ^w_sync;
  assign w_tick      = (r_state == SAMPLE) && (r_div_cnt == DIV_LAST);
  assign w_word_done = w_tick && (r_bit_cnt == BIT_LAST);
  // r_rep_cnt == 0 marks the first tick of a SAMPLE run (no history yet);
  // REP_LAST >= 1 so that case can never register as a hit.
  assign w_rep_hit   = w_tick && (w_raw_bit == r_prev_bit) && (r_rep_cnt == REP_LAST);
  assign w_xfer      = r_valid && ready_i;
  assign w_buf_free  = !r_valid || ready_i;
  assign w_word      = {r_shift[WORD_WIDTH-2:0], w_raw_bit};

  assign data_o  = r_data;
  assign valid_o = r_valid;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_enter_warm   = 1'b0;
    w_enter_sample = 1'b0;
    w_enter_fault  = 1'b0;
    w_load_word    = 1'b0;
    w_load_shift   = 1'b0;
    ro_halt_o      = 1'b1;
    busy_o         = 1'b0;
    fault_o        = 1'b0;

    case (r_state)
      IDLE: begin
        if (en_i) begin
          w_state_nxt  = WARMUP;
          w_enter_warm = 1'b1;
        end
      end

      WARMUP: begin
        ro_halt_o = 1'b0;
        busy_o    = 1'b1;
        if (!en_i) begin
          w_state_nxt = IDLE;
        end else if (r_warm_cnt == WARM_LAST) begin
          w_state_nxt    = SAMPLE;
          w_enter_sample = 1'b1;
        end
      end

      SAMPLE: begin
        ro_halt_o = 1'b0;
        busy_o    = 1'b1;
        // Health failure outranks both disable and word completion.
        if (w_rep_hit) begin
          w_state_nxt   = FAULT;
          w_enter_fault = 1'b1;
        end else if (!en_i) begin
          w_state_nxt = IDLE;
        end else if (w_word_done) begin
          if (w_buf_free) begin
            w_load_word = 1'b1;
          end else begin
            w_state_nxt = HOLD;
          end
        end
      end

      HOLD: begin
        // Rings stay released so they need no new warm-up on resume.
        ro_halt_o = 1'b0;
        busy_o    = 1'b1;
        if (!en_i) begin
          w_state_nxt = IDLE;
        end else if (w_buf_free) begin
          w_state_nxt    = SAMPLE;
          w_load_shift   = 1'b1;
          w_enter_sample = 1'b1;
        end
      end

      FAULT: begin
        fault_o = 1'b1;
        if (clear_fault_i) begin
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_warm_cnt <= '0;
      r_div_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_rep_cnt  <= '0;
      r_prev_bit <= 1'b0;
      r_shift    <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
    end else begin
      // Warm-up counter saturates at its terminal value.
      if (w_enter_warm) begin
        r_warm_cnt <= '0;
      end else if ((r_state == WARMUP) && (r_warm_cnt != WARM_LAST)) begin
        r_warm_cnt <= r_warm_cnt + WARM_W'(1);
      end

      // Divider only runs in SAMPLE, so it is frozen through HOLD.
      if (w_enter_sample) begin
        r_div_cnt <= '0;
      end else if (r_state == SAMPLE) begin
        r_div_cnt <= w_tick ? '0 : r_div_cnt + DIV_W'(1);
      end

      // The completed word lives in r_shift from here on, so the bit
      // count restarts even when the word has to wait in HOLD.
      if (w_enter_sample) begin
        r_bit_cnt <= '0;
      end else if (w_tick) begin
        r_bit_cnt <= w_word_done ? '0 : r_bit_cnt + BIT_W'(1);
      end

      if (w_tick) begin
        r_shift    <= w_word;
        r_prev_bit <= w_raw_bit;
      end

      // Every entry into SAMPLE drops the repetition history: the
      // sampled stream has a gap, so the previous bit is not adjacent.
      if (w_enter_sample) begin
        r_rep_cnt <= '0;
      end else if (w_tick) begin
        if ((r_rep_cnt == '0) || (w_raw_bit != r_prev_bit)) begin
          r_rep_cnt <= REP_W'(1);
        end else if (r_rep_cnt != REP_LAST) begin
          r_rep_cnt <= r_rep_cnt + REP_W'(1);
        end
      end

      // Output buffer: a load overrides the transfer clear, so a
      // transfer and a load in one cycle leave valid set (no bubble).
      if (w_enter_fault) begin
        r_valid <= 1'b0;
        r_data  <= '0;
      end else if (w_load_word) begin
        r_valid <= 1'b1;
        r_data  <= w_word;
      end else if (w_load_shift) begin
        r_valid <= 1'b1;
        r_data  <= r_shift;
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_trng_ro_ctrl.sv
// Directed bench for trng_ro_ctrl with NUM_RO=2, WORD_WIDTH=8,
// WARMUP_CYCLES=4, SAMPLE_DIV=2, REP_LIMIT=4.
// ro_bits_i is driven from a cycle counter so each sample tick sees a known bit.
module tb_trng_ro_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       ready = 1'b0;
  logic       clear = 1'b0;
  logic [1:0] ro_bits = 2'b00;
  logic       halt;
  logic       valid;
  logic       busy;
  logic       fault;
  logic [7:0] data;

  int   n_tests = 0;
  int   n_fail = 0;
  int   pc = 0;
  logic mode_const = 1'b0;

  always #5 clk = ~clk;

  trng_ro_ctrl #(
    .NUM_RO        (2),
    .WORD_WIDTH    (8),
    .WARMUP_CYCLES (4),
    .SAMPLE_DIV    (2),
    .REP_LIMIT     (4)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .en_i          (en),
    .ro_bits_i     (ro_bits),
    .ro_halt_o     (halt),
    .data_o        (data),
    .valid_o       (valid),
    .ready_i       (ready),
    .busy_o        (busy),
    .fault_o       (fault),
    .clear_fault_i (clear)
  );

  typedef struct {
    int         steps;
    logic       en;
    logic       rdy;
    logic       restart;
    logic       e_halt;
    logic       e_busy;
    logic       e_valid;
    logic [7:0] e_data;
    logic       chk_dat;
  } vec_t;

  vec_t tbl[$];

  // The value set with pc=p is sampled by the DUT at the p-th edge after
  // the restart. Alternating mode: pc mod 4 in {0,1} -> 1, {2,3} -> 0.
  // The XOR of both rings carries the bit; ring 0 is random.
  task automatic drive_ro();
    logic b;
    logic r;
    b = mode_const ? 1'b1 : ((pc % 4) < 2);
    r = 1'($urandom);
    ro_bits = {b ^ r, r};
  endtask

  task automatic restart_pattern();
    pc = 0;
    drive_ro();
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      pc++;
      drive_ro();
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic e_halt, input logic e_busy,
                         input logic e_valid, input logic e_fault,
                         input logic [7:0] e_data, input logic chk_dat);
    chk({name, ".halt"},  {7'd0, halt},  {7'd0, e_halt});
    chk({name, ".busy"},  {7'd0, busy},  {7'd0, e_busy});
    chk({name, ".valid"}, {7'd0, valid}, {7'd0, e_valid});
    chk({name, ".fault"}, {7'd0, fault}, {7'd0, e_fault});
    if (chk_dat) chk({name, ".data"}, data, e_data);
  endtask

  task automatic add(input int steps, input logic en_v, input logic rdy_v,
                     input logic rs, input logic h, input logic b, input logic v,
                     input logic [7:0] d, input logic cd);
    vec_t e;
    e.steps = steps; e.en = en_v; e.rdy = rdy_v; e.restart = rs;
    e.e_halt = h; e.e_busy = b; e.e_valid = v; e.e_data = d; e.chk_dat = cd;
    tbl.push_back(e);
  endtask

  initial begin
    // k0 = first edge with en=1; words land at k0+20, +36, +52 ...
    add( 1, 1, 1, 1, 0, 1, 0, 8'h00, 1);  // k0    released, busy
    add(19, 1, 1, 0, 0, 1, 0, 8'h00, 1);  // k0+19 eighth tick not yet
    add( 1, 1, 1, 0, 0, 1, 1, 8'hAA, 1);  // k0+20 first word
    add( 1, 1, 1, 0, 0, 1, 0, 8'hAA, 0);  // k0+21 taken, 1-cycle valid
    add(14, 1, 1, 0, 0, 1, 0, 8'hAA, 0);  // k0+35
    add( 1, 1, 1, 0, 0, 1, 1, 8'hAA, 1);  // k0+36 second word, 16 later
    add( 1, 1, 1, 0, 0, 1, 0, 8'hAA, 0);  // k0+37 taken
    add(15, 1, 0, 0, 0, 1, 1, 8'hAA, 1);  // k0+52 third word, ready low
    add( 8, 1, 0, 0, 0, 1, 1, 8'hAA, 1);  // k0+60 stable
    add(16, 1, 0, 0, 0, 1, 1, 8'hAA, 1);  // k0+76 HOLD since k0+68
    add( 1, 1, 0, 0, 0, 1, 1, 8'hAA, 1);  // k0+77 40th edge with ready low
    add( 1, 1, 1, 0, 0, 1, 1, 8'hAA, 1);  // k0+78 transfer + reload
    add( 1, 1, 1, 0, 0, 1, 0, 8'hAA, 0);  // k0+79 reloaded word taken
    add(14, 1, 1, 0, 0, 1, 0, 8'hAA, 0);  // k0+93 divider was frozen
    add( 1, 1, 1, 0, 0, 1, 1, 8'h55, 1);  // k0+94 resumed on new phase
    add(10, 1, 0, 0, 0, 1, 1, 8'h55, 1);  // k0+104 five samples pending
    add( 1, 0, 0, 0, 1, 0, 1, 8'h55, 1);  // k0+105 disabled -> IDLE
    add( 3, 0, 0, 0, 1, 0, 1, 8'h55, 1);  // word retained
    add( 1, 0, 1, 0, 1, 0, 0, 8'h55, 0);  // pending word transfers
    add( 1, 1, 1, 1, 0, 1, 0, 8'h55, 0);  // k1 re-enable
    add(19, 1, 1, 0, 0, 1, 0, 8'h55, 0);  // k1+19
    add( 1, 1, 1, 0, 0, 1, 1, 8'hAA, 1);  // k1+20 fresh full word

    drive_ro();
    step(3);
    rst = 1'b0;
    chk_all("reset", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

    foreach (tbl[i]) begin
      en    = tbl[i].en;
      ready = tbl[i].rdy;
      if (tbl[i].restart) restart_pattern();
      step(tbl[i].steps);
      chk_all($sformatf("vec%0d", i), tbl[i].e_halt, tbl[i].e_busy,
              tbl[i].e_valid, 1'b0, tbl[i].e_data, tbl[i].chk_dat);
    end

    // Health test: constant 1 faults on the 4th tick, buffered word dropped.
    en = 1'b0; ready = 1'b0;
    step(1);
    chk_all("idle_hold", 1'b1, 1'b0, 1'b1, 1'b0, 8'hAA, 1'b1);
    en = 1'b1; mode_const = 1'b1;
    restart_pattern();
    step(1);
    chk_all("const_k2", 1'b0, 1'b1, 1'b1, 1'b0, 8'hAA, 1'b1);
    step(11);
    chk_all("const_tick3", 1'b0, 1'b1, 1'b1, 1'b0, 8'hAA, 1'b1);
    step(1);
    chk_all("fault_set", 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1);
    ready = 1'b1;
    step(3);
    chk_all("fault_sticky", 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    clear = 1'b1; en = 1'b0;
    step(1);
    clear = 1'b0;
    chk_all("fault_clear", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    // Async reset mid-operation; clear_fault_i ignored outside FAULT.
    mode_const = 1'b0; en = 1'b1; ready = 1'b0;
    restart_pattern();
    step(1);
    chk_all("k3", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    step(10);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk_all("clear_noop", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    step(9);
    chk_all("k3_word", 1'b0, 1'b1, 1'b1, 1'b0, 8'hAA, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    step(2);
    chk_all("rst_held", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    rst = 1'b0; en = 1'b0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/trng_ro_ctrl.md
Name: trng_ro_ctrl

Overview:
Controller for a bank of NUM_RO ring oscillators.
- Releases the rings from halt and waits a warm-up period.
- Samples the rings at a divided rate, XOR-folds them into one raw bit per sample and packs bits into WORD_WIDTH words.
- Hands each word out over a valid/ready interface with a one-word output buffer.
- Runs a repetition-count health test and halts the rings on failure.
Sits between the RO bank and the bus-side TRNG register interface.

Parameters:
NUM_RO, 4, number of ring oscillators sampled (>=1)
WORD_WIDTH, 32, bits per output word (>=2)
WARMUP_CYCLES, 64, clk cycles between ring release and first sample (>=1)
SAMPLE_DIV, 8, clk cycles per raw-bit sample (>=1)
REP_LIMIT, 32, consecutive identical raw bits that trigger fault (>=2)

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous reset, active-high
en_i  in  1  level enable for entropy generation
ro_bits_i  in  NUM_RO  raw ring outputs, asynchronous to clk_i
ro_halt_o  out  1  drives each ring's enable input; 1 = ring input forced high, oscillation stopped
data_o  out  WORD_WIDTH  output word
valid_o  out  1  data_o valid
ready_i  in  1  consumer accepts data_o
busy_o  out  1  FSM not in IDLE or FAULT
fault_o  out  1  sticky health-test failure
clear_fault_i  in  1  clears fault, returns to IDLE

Behaviour:
- Reset values: ro_halt_o=1, data_o=0, valid_o=0, busy_o=0, fault_o=0, FSM=IDLE, all counters 0.
- Synchronizer: ro_bits_i passes through a 2-flop synchronizer per bit. raw_bit = XOR of the synchronized vector.
- FSM states:
  - IDLE: ro_halt_o=1. en_i=1 -> WARMUP, warm-up counter cleared.
  - WARMUP: ro_halt_o=0. Counter increments every cycle. At count==WARMUP_CYCLES-1 -> SAMPLE, with divider, bit count and repetition counter cleared.
  - SAMPLE: ro_halt_o=0. Divider counts 0..SAMPLE_DIV-1 and wraps; a sample tick occurs when divider==SAMPLE_DIV-1. On each tick: shift_reg <= {shift_reg[W-2:0], raw_bit}, bit_cnt increments.
    - The tick that brings bit_cnt to WORD_WIDTH is the word-complete tick.
    - On word-complete, if the output buffer is free (valid_o=0, or ready_i=1 this cycle): data_o is loaded with the completed word, valid_o=1, bit_cnt=0, FSM stays in SAMPLE.
    - Otherwise -> HOLD.
  - HOLD: rings keep running. Divider frozen, no sampling. When the buffer frees (handshake completes) -> load data_o, bit_cnt=0 -> SAMPLE with divider=0.
  - FAULT: ro_halt_o=1, valid_o=0, fault_o=1. clear_fault_i=1 -> IDLE, fault_o=0.
- Handshake:
  - A transfer occurs when valid_o&ready_i.
  - data_o is stable while valid_o=1 and ready_i=0.
  - A transfer and a new load in the same cycle leave valid_o=1 with the new word (no bubble).
  - Latency from word-complete tick to valid_o=1 is one cycle.
- Health test:
  - Each tick compares raw_bit with the previous sample.
  - Equal: rep_cnt increments. Different: rep_cnt=1. The first tick after entering SAMPLE sets rep_cnt=1.
  - rep_cnt reaching REP_LIMIT -> FAULT next cycle. The partial word and the buffered word are discarded.
  - A fault has priority over a word-complete on the same tick.
- en_i deasserted in WARMUP/SAMPLE/HOLD -> IDLE next cycle. The partial word is discarded. A buffered valid word is retained until transferred. en_i is ignored in FAULT.
- clear_fault_i outside FAULT has no effect. Reset mid-operation returns all state to reset values immediately.
- Counter widths: $clog2 of each parameter (minimum 1 bit). No wrap beyond the terminal values.

Decomposition:
- Package trng_pkg:
  - State enum trng_ctrl_state_e {IDLE, WARMUP, SAMPLE, HOLD, FAULT}.
  - Default parameter constants.
- Sub-module trng_sync: a parameterized N-bit 2-flop synchronizer, reusable by other TRNG blocks.
- Divider, health test and packer stay inline.

Test Plan:
Bench parameters: NUM_RO=2, WORD_WIDTH=8, WARMUP_CYCLES=4, SAMPLE_DIV=2, REP_LIMIT=4. The bench models ro_bits_i as a driven pattern.
1. Reset then en_i=1 -> ro_halt_o falls the cycle after en_i, first sample tick occurs 4+2 cycles later, busy_o=1.
2. Alternating raw_bit 1,0,1,0..., ready_i=1 -> data_o=8'hAA, valid_o high for 1 cycle, next word 8 ticks (16 cycles) later.
3. Same stream, ready_i=0 for 40 cycles -> first word held stable at 8'hAA, second word completes and FSM enters HOLD, no sampling occurs. ready_i=1 -> 8'hAA transfers, 8'hAA is reloaded with no bubble, sampling resumes.
4. Constant raw_bit=1 -> fault_o=1 after the 4th tick, ro_halt_o=1, valid_o=0. clear_fault_i pulse -> IDLE, fault_o=0.
5. Deassert en_i after 5 samples with a valid word pending -> IDLE, ro_halt_o=1, pending word still transfers on ready_i. Re-enable -> fresh warm-up, bit_cnt starts at 0.
6. Assert rst_i mid-SAMPLE, asynchronously to clk_i -> all outputs return to reset values within the same cycle.
